// File: rtl/stream_boxcar_decimator.sv
// stream_boxcar_decimator
// Sums blocks of R consecutive valid signed samples and emits one registered
// sum per block (boxcar filter followed by decimate-by-R). R is sampled from
// ratio_i when a block starts and held for the rest of that block. The output
// is wide enough that the sum of a full block can never overflow.
module stream_boxcar_decimator #(
  parameter int DATA_WIDTH  = 16,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [RATIO_WIDTH-1:0]              ratio_i,
  input  logic                                clear_i,
  input  logic signed [DATA_WIDTH-1:0]        data_i_tdata,
  input  logic                                data_i_tvalid,
  output logic signed [DATA_WIDTH+RATIO_WIDTH-1:0] data_o_tdata,
  output logic                                data_o_tvalid
);

  localparam int OUT_WIDTH = DATA_WIDTH + RATIO_WIDTH;

  // Block state
  logic signed [OUT_WIDTH-1:0]   r_acc;
  logic        [RATIO_WIDTH-1:0] r_count;
  logic        [RATIO_WIDTH-1:0] r_ratio_q;
  logic signed [OUT_WIDTH-1:0]   r_out_data;
  logic                          r_out_valid;

  // Datapath helpers
  logic                          w_first;
  logic        [RATIO_WIDTH-1:0] w_ratio_in;
  logic        [RATIO_WIDTH-1:0] w_r_eff;
  logic signed [OUT_WIDTH-1:0]   w_sample_ext;
  logic signed [OUT_WIDTH-1:0]   w_sum;
  logic                          w_accept;
  logic                          w_last;

  // A ratio of zero is treated as one so every block holds at least a sample.
  assign w_ratio_in   = (ratio_i == '0) ? RATIO_WIDTH'(1) : ratio_i;
  // The first sample of a block uses the live ratio; later samples the latched one.
  assign w_first      = (r_count == '0);
  assign w_r_eff      = w_first ? w_ratio_in : r_ratio_q;
  assign w_sample_ext = {{RATIO_WIDTH{data_i_tdata[DATA_WIDTH-1]}}, data_i_tdata};
  // The accumulator is ignored on the first sample, so a stale value never leaks in.
  assign w_sum        = (w_first ? '0 : r_acc) + w_sample_ext;
  assign w_accept     = data_i_tvalid & ~clear_i;
  // Compare one bit wider so count+1 cannot wrap before matching r_eff.
  assign w_last       = ({1'b0, r_count} + (RATIO_WIDTH+1)'(1)) == {1'b0, w_r_eff};

  // Block accumulation, ratio latch and registered output
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; the asynchronous reset clears the whole state.
    if (!resetn) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ratio_q   <= RATIO_WIDTH'(1);
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (clear_i) begin
      // Abort the block; any sample presented this cycle is dropped.
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_first) begin
        r_ratio_q <= w_ratio_in;
      end
      if (w_last) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_count     <= '0;
      end else begin
        r_acc       <= w_sum;
        r_count     <= r_count + RATIO_WIDTH'(1);
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign data_o_tdata  = r_out_data;
  assign data_o_tvalid = r_out_valid;

endmodule
